// File: rtl/mem_port_arbiter.sv
// Arbitrates a single unified memory port between instruction fetch and data
// load/store, with request/ack sequencing, a bounded-starvation grant rule and a timeout abort.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       TIMEOUT      = 16,
  parameter int unsigned       D_STREAK_MAX = 4,
  parameter logic [DATA_W-1:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned SW = $clog2(D_STREAK_MAX + 1);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic              own_data_q, own_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              data_wins;

  // Data has priority until it has won D_STREAK_MAX times in a row over a waiting fetch.
  assign data_wins = d_req_i && !(if_req_i && (streak_q == SW'(D_STREAK_MAX)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      own_data_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      streak_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    streak_d   = streak_q;
    cnt_d      = '0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (if_req_i || d_req_i)) begin
          state_d = BUSY;
          if (data_wins) begin
            own_data_d = 1'b1;
            addr_d     = d_addr_i;
            we_d       = d_we_i;
            wdata_d    = d_wdata_i;
            if (!if_req_i)
              streak_d = '0;
            else if (streak_q != SW'(D_STREAK_MAX))
              streak_d = streak_q + SW'(1);
          end else begin
            own_data_d = 1'b0;
            addr_d     = if_addr_i;
            we_d       = 1'b0;
            wdata_d    = '0;
            streak_d   = '0;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack_i) begin
          state_d = RESP;
          if (own_data_q) d_rdata_d = mem_rdata_i;
          else            if_rdata_d = mem_rdata_i;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          // A timed-out store leaves the data read register untouched.
          if (!we_q) begin
            if (own_data_q) d_rdata_d = ERR_DATA;
            else            if_rdata_d = ERR_DATA;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == BUSY) && !rst_i;
  assign mem_we_o    = we_q && (state_q == BUSY);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == RESP) && !own_data_q;
  assign d_ack_o     = (state_q == RESP) && own_data_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = !rst_i && ((if_req_i && !if_ack_o) || (d_req_i && !d_ack_o));

endmodule
